// File: rtl/muldiv_hilo_ctrl.sv
// Multi-cycle MULT/MADD/MSUB/DIV sequencer and owner of the HI/LO pair.
// Products arrive as 16x16 partials from EX; division is delegated to an external divider.
module muldiv_hilo_ctrl #(
  parameter int DIV_TIMEOUT = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic        op_signed,
  input  logic [31:0] opr1,
  input  logic [31:0] opr2,
  input  logic [63:0] mulhi,
  input  logic [63:0] mullo,
  input  logic        mul_s,
  input  logic        flush,
  output logic        div_start,
  output logic        div_signed,
  input  logic        div_ready,
  input  logic [31:0] div_quot,
  input  logic [31:0] div_rem,
  output logic        div_abort,
  output logic        div_err,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq
);
  localparam logic [2:0] OP_MULT = 3'd1, OP_MADD = 3'd2, OP_MSUB = 3'd3,
                         OP_DIV  = 3'd4, OP_MTHI = 3'd5, OP_MTLO = 3'd6;
  localparam int CW = $clog2(DIV_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, MUL, ACC, DIV_WAIT, DONE} state_t;

  state_t         state;
  logic [63:0]    mh_q, ml_q, prod_q;
  logic           ms_q, sgn_q;
  logic [2:0]     op_q;
  logic [CW-1:0]  cnt;
  logic [63:0]    prod_raw, prod, acc;
  logic           is_mul, is_div, div_go, timeout;

  assign is_mul  = op_valid && (op == OP_MULT || op == OP_MADD || op == OP_MSUB);
  assign is_div  = op_valid && (op == OP_DIV);
  assign div_go  = is_div && (opr2 != 32'd0);
  assign timeout = (cnt == CW'(DIV_TIMEOUT - 1));

  // hh at 32, lh/hl at 16, ll at 0: recombine the 16x16 partials of the magnitudes
  assign prod_raw = {32'd0, ml_q[31:0]} + ({32'd0, ml_q[63:32]} << 16)
                  + ({32'd0, mh_q[31:0]} << 16) + ({32'd0, mh_q[63:32]} << 32);
  assign prod     = ms_q ? (~prod_raw + 64'd1) : prod_raw;
  assign acc      = (op_q == OP_MSUB) ? ({hi_o, lo_o} - prod_q) : ({hi_o, lo_o} + prod_q);

  always_comb begin
    stallreq   = 1'b0;
    div_start  = 1'b0;
    div_signed = 1'b0;
    div_abort  = 1'b0;
    div_err    = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: if (!flush) begin
          stallreq   = is_mul || is_div;
          div_start  = div_go;
          div_signed = div_go && op_signed;
        end
        MUL, ACC: stallreq = !flush;
        DIV_WAIT: begin
          if (flush) div_abort = 1'b1;
          else begin
            stallreq = 1'b1;
            if (!div_ready) begin
              if (timeout) begin
                div_abort = 1'b1;
                div_err   = 1'b1;
              end else begin
                div_start  = 1'b1;
                div_signed = sgn_q;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      hi_o   <= '0;
      lo_o   <= '0;
      mh_q   <= '0;
      ml_q   <= '0;
      prod_q <= '0;
      ms_q   <= 1'b0;
      sgn_q  <= 1'b0;
      op_q   <= '0;
      cnt    <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (op_valid) begin
          case (op)
            OP_MTHI: hi_o <= opr1;
            OP_MTLO: lo_o <= opr1;
            OP_MULT, OP_MADD, OP_MSUB: begin
              mh_q  <= mulhi;
              ml_q  <= mullo;
              ms_q  <= mul_s;
              op_q  <= op;
              state <= MUL;
            end
            OP_DIV: begin
              if (opr2 == 32'd0) state <= DONE;
              else begin
                sgn_q <= op_signed;
                cnt   <= '0;
                state <= DIV_WAIT;
              end
            end
            default: ;
          endcase
        end
        MUL: begin
          prod_q <= prod;
          if (op_q == OP_MULT) begin
            {hi_o, lo_o} <= prod;
            state        <= DONE;
          end else state <= ACC;
        end
        ACC: begin
          {hi_o, lo_o} <= acc;
          state        <= DONE;
        end
        DIV_WAIT: begin
          if (div_ready) begin
            lo_o  <= div_quot;
            hi_o  <= div_rem;
            state <= DONE;
          end else if (timeout) state <= DONE;
          else cnt <= cnt + CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed bench for muldiv_hilo_ctrl; expected HI/LO pairs queue at issue and pop at completion.
module tb_muldiv_hilo_ctrl;
  localparam logic [2:0] NOP = 3'd0, MULT = 3'd1, MADD = 3'd2, MSUB = 3'd3,
                         DIV = 3'd4, MTHI = 3'd5, MTLO = 3'd6;

  logic        clk = 1'b0, rst;
  logic        op_valid, op_signed, mul_s, flush, div_ready;
  logic [2:0]  op;
  logic [31:0] opr1, opr2, div_quot, div_rem, hi_o, lo_o;
  logic [63:0] mulhi, mullo;
  logic        div_start, div_signed, div_abort, div_err, stallreq;

  int n_tests = 0, n_fail = 0;
  logic [31:0] hi_m = '0, lo_m = '0;
  logic [63:0] sb[$];

  muldiv_hilo_ctrl #(.DIV_TIMEOUT(48)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .op_signed(op_signed),
    .opr1(opr1), .opr2(opr2), .mulhi(mulhi), .mullo(mullo), .mul_s(mul_s),
    .flush(flush), .div_start(div_start), .div_signed(div_signed),
    .div_ready(div_ready), .div_quot(div_quot), .div_rem(div_rem),
    .div_abort(div_abort), .div_err(div_err), .hi_o(hi_o), .lo_o(lo_o),
    .stallreq(stallreq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_pop(input string tag);
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s: scoreboard empty", tag);
    end else chk(tag, {hi_o, lo_o}, sb.pop_front());
  endtask

  task automatic idle_in();
    op_valid = 0; op = NOP; op_signed = 0; opr1 = '0; opr2 = '0;
    mulhi = '0; mullo = '0; mul_s = 0; flush = 0;
    div_ready = 0; div_quot = '0; div_rem = '0;
  endtask

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  task automatic mt(input logic [2:0] o, input logic [31:0] v, input string tag);
    op_valid = 1; op = o; opr1 = v;
    #1 chk({tag, "_nostall"}, 64'(stallreq), 64'd0);
    edge1();
    idle_in();
    if (o == MTHI) hi_m = v; else lo_m = v;
    sb.push_back({hi_m, lo_m});
    chk_pop(tag);
  endtask

  // Presents the op with EX-style partials, then scrambles EX inputs while stalled.
  task automatic do_mul(input logic [2:0] o, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input int exp_stall, input string tag);
    logic [31:0] ua, ub, hh, lh, hl, ll;
    logic [63:0] p, e;
    int n;
    ua = (s && a[31]) ? -a : a;
    ub = (s && b[31]) ? -b : b;
    hh = 32'(ua[31:16]) * 32'(ub[31:16]);
    lh = 32'(ua[15:0])  * 32'(ub[31:16]);
    hl = 32'(ua[31:16]) * 32'(ub[15:0]);
    ll = 32'(ua[15:0])  * 32'(ub[15:0]);
    p = 64'(ua) * 64'(ub);
    if (s && (a[31] ^ b[31])) p = -p;
    e = (o == MADD) ? {hi_m, lo_m} + p : (o == MSUB) ? {hi_m, lo_m} - p : p;
    sb.push_back(e);
    {hi_m, lo_m} = e;
    op_valid = 1; op = o; op_signed = s; opr1 = a; opr2 = b;
    mulhi = {hh, lh}; mullo = {hl, ll}; mul_s = s && (a[31] ^ b[31]);
    #1 n = 0;
    while (stallreq === 1'b1 && n < 10) begin
      n++;
      edge1();
      op_valid = 0; mulhi = {$urandom, $urandom}; mullo = {$urandom, $urandom}; mul_s = ~mul_s;
      #1;
    end
    chk({tag, "_stalls"}, 64'(n), 64'(exp_stall));
    chk_pop(tag);
    edge1();
    idle_in();
  endtask

  initial begin
    int c, nstart, ab_at, err_at, nab, nerr;
    logic sgn_ok;
    idle_in();
    rst = 1;
    edge1(); edge1();
    chk("reset_hilo", {hi_o, lo_o}, 64'd0);
    chk("reset_ctl", {59'd0, stallreq, div_start, div_signed, div_abort, div_err}, 64'd0);
    rst = 0;
    edge1();

    mt(MTLO, 32'h1234_5678, "mtlo");
    do_mul(MULT, 1'b1, -32'sd3, 32'd7, 2, "mult_neg");
    chk("mult_neg_val", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFEB);
    mt(MTHI, 32'd0, "mthi0");
    mt(MTLO, 32'd5, "mtlo5");
    do_mul(MSUB, 1'b0, 32'd2, 32'd3, 3, "msub_wrap");
    chk("msub_wrap_val", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFF);
    do_mul(MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, "mult_max");
    do_mul(MADD, 1'b1, 32'h0001_2345, -32'sh0067_89AB, 3, "madd_s");
    do_mul(MULT, 1'b1, -32'sh8000_0000, -32'sh8000_0000, 2, "mult_minint");

    // DIV signed -7/2: divider answers in the 11th cycle after issue
    sb.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    {hi_m, lo_m} = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
    nstart = 0; sgn_ok = 1;
    for (c = 1; c <= 11; c++) begin
      op_valid = (c == 1); op = DIV; op_signed = 1; opr1 = -32'sd7; opr2 = 32'd2;
      div_ready = (c == 11); div_quot = 32'hFFFF_FFFD; div_rem = 32'hFFFF_FFFF;
      #1;
      if (div_start === 1'b1) begin
        nstart++;
        if (div_signed !== 1'b1) sgn_ok = 0;
      end
      edge1();
    end
    idle_in();
    #1;
    chk("div_start_cycles", 64'(nstart), 64'd10);
    chk("div_signed", 64'(sgn_ok), 64'd1);
    chk("div_done_nostall", 64'(stallreq), 64'd0);
    chk_pop("div_result");
    edge1();

    // stray divider pulse in IDLE must not touch HI/LO
    div_ready = 1; div_quot = 32'hDEAD_BEEF; div_rem = 32'hCAFE_F00D;
    edge1();
    idle_in();
    sb.push_back({hi_m, lo_m});
    chk_pop("stray_ready");

    // DIV by zero: one stall cycle, no divider start
    op_valid = 1; op = DIV; opr1 = 32'd9; opr2 = 32'd0;
    #1;
    chk("div0_ctl", {62'd0, stallreq, div_start}, 64'h2);
    edge1();
    idle_in();
    #1;
    chk("div0_done", {62'd0, stallreq, div_start}, 64'h0);
    sb.push_back({hi_m, lo_m});
    chk_pop("div0_hilo");
    edge1();

    // divider never ready: abort/err on the 48th wait cycle
    ab_at = -1; err_at = -1; nab = 0; nerr = 0;
    for (c = 0; c < 70; c++) begin
      op_valid = (c == 0); op = DIV; opr1 = 32'd100; opr2 = 32'd3;
      #1;
      if (div_abort === 1'b1) begin nab++; ab_at = c; end
      if (div_err === 1'b1) begin nerr++; err_at = c; end
      if (stallreq !== 1'b1) break;
      edge1();
    end
    idle_in();
    chk("timeout_abort_at", 64'(ab_at), 64'd48);
    chk("timeout_err_at", 64'(err_at), 64'd48);
    chk("timeout_pulses", {32'(nab), 32'(nerr)}, {32'd1, 32'd1});
    sb.push_back({hi_m, lo_m});
    chk_pop("timeout_hilo");
    edge1();
    mt(MTHI, 32'h0000_0042, "after_timeout");

    // MADD flushed in ACC: no write, back in IDLE at once
    op_valid = 1; op = MADD; mullo = {32'd0, 32'd1000}; mulhi = '0; mul_s = 0;
    edge1();
    idle_in();
    edge1();
    flush = 1;
    #1 chk("flush_acc_nostall", 64'(stallreq), 64'd0);
    edge1();
    idle_in();
    op_valid = 1; op = MTLO; opr1 = 32'hA5A5_A5A5;
    edge1();
    idle_in();
    lo_m = 32'hA5A5_A5A5;
    sb.push_back({hi_m, lo_m});
    chk_pop("flush_acc_hilo");

    // flush during DIV_WAIT, coinciding with div_ready: abort, result dropped
    op_valid = 1; op = DIV; opr1 = 32'd50; opr2 = 32'd7;
    edge1();
    idle_in();
    edge1();
    flush = 1; div_ready = 1; div_quot = 32'd7; div_rem = 32'd1;
    #1 chk("flush_div_ctl", {60'd0, div_abort, div_err, stallreq, div_start}, 64'h8);
    edge1();
    idle_in();
    #1 chk("flush_div_idle", 64'(stallreq), 64'd0);
    sb.push_back({hi_m, lo_m});
    chk_pop("flush_div_hilo");
    edge1();

    // flush with an op in IDLE: not accepted
    op_valid = 1; op = MTHI; opr1 = 32'h7777_7777; flush = 1;
    #1 chk("flush_idle_nostall", 64'(stallreq), 64'd0);
    edge1();
    idle_in();
    sb.push_back({hi_m, lo_m});
    chk_pop("flush_idle_hilo");

    // reset mid-DIV: no abort pulse, HI/LO cleared
    op_valid = 1; op = DIV; opr1 = 32'd8; opr2 = 32'd2;
    edge1();
    idle_in();
    edge1();
    rst = 1;
    #1 chk("rst_mid_ctl", {60'd0, div_abort, div_err, stallreq, div_start}, 64'h0);
    edge1();
    rst = 0;
    chk("rst_mid_hilo", {hi_o, lo_o}, 64'd0);
    edge1();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
